// File: rtl/assert_collector_if.sv
// Check-result handshake between a test's checking logic (master) and
// the assert_collector (slave).
interface assert_collector_if #(
  parameter int ID_W = 8
);
  logic            chk_valid;
  logic            chk_ready;
  logic            chk_pass;
  logic [ID_W-1:0] chk_id;

  modport master (output chk_valid, chk_pass, chk_id, input chk_ready);
  modport slave  (input chk_valid, chk_pass, chk_id, output chk_ready);
endinterface

// File: rtl/assert_collector.sv
// assert_collector: reduces a stream of pass/fail check results into a sticky
// ERROR flag, pass/fail counters and the id of the first failing check.
// Optional macro ASSERT_LOG_EN (simulation only) prints ":assert:(%b)" for each
// accepted result and for the final verdict on entering DONE.
module assert_collector #(
  parameter int ID_W     = 8,
  parameter int CNT_W    = 16,
  parameter int EXPECTED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  assert_collector_if.slave chk,
  output logic             ERROR,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [ID_W-1:0]  first_fail_id,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   EXP_TOTAL = (CNT_W+1)'(EXPECTED);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pass_nxt, fail_nxt;
  logic [ID_W-1:0]  ffid_nxt;
  logic             ffvld_nxt, err_nxt;
  logic [CNT_W:0]   total;
  logic             acc;

  // chk_ready is only high in COLLECT, so acceptance implies COLLECT
  assign acc = chk.chk_valid && chk.chk_ready;

  // Next state and next result values; start restarts from any state
  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_cnt;
    fail_nxt  = fail_cnt;
    ffid_nxt  = first_fail_id;
    ffvld_nxt = first_fail_vld;
    err_nxt   = ERROR;
    total     = '0;
    if (start) begin
      // Restart discards whatever result is offered this cycle
      state_nxt = COLLECT;
      pass_nxt  = '0;
      fail_nxt  = '0;
      ffid_nxt  = '0;
      ffvld_nxt = 1'b0;
      err_nxt   = 1'b0;
    end else if (state == COLLECT) begin
      if (acc) begin
        if (chk.chk_pass) begin
          if (pass_cnt == CNT_MAX) err_nxt = 1'b1;
          else                     pass_nxt = pass_cnt + 1'b1;
        end else begin
          err_nxt = 1'b1;
          if (fail_cnt != CNT_MAX) fail_nxt = fail_cnt + 1'b1;
          if (!first_fail_vld) begin
            ffid_nxt  = chk.chk_id;
            ffvld_nxt = 1'b1;
          end
        end
      end
      if (finish) begin
        state_nxt = DONE;
        // Count check uses the post-update counters so a result accepted
        // alongside finish is included; verdict is visible as done rises
        total = {1'b0, pass_nxt} + {1'b0, fail_nxt};
        if (EXPECTED != 0 && total != EXP_TOTAL) err_nxt = 1'b1;
      end
    end
  end

  // State and result registers; ready/done are registered decodes of next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_id  <= '0;
      first_fail_vld <= 1'b0;
      ERROR          <= 1'b0;
      chk.chk_ready  <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      pass_cnt       <= pass_nxt;
      fail_cnt       <= fail_nxt;
      first_fail_id  <= ffid_nxt;
      first_fail_vld <= ffvld_nxt;
      ERROR          <= err_nxt;
      chk.chk_ready  <= (state_nxt == COLLECT);
      done           <= (state_nxt == DONE);
    end
  end

`ifdef ASSERT_LOG_EN
  // Simulation log of accepted results and the final verdict
  always_ff @(posedge clk) begin
    if (!rst && !start && acc) $display(":assert:(%b)", chk.chk_pass);
    if (!rst && !start && state == COLLECT && state_nxt == DONE)
      $display(":assert:(%b)", !err_nxt);
  end
`else
  // Logging disabled: no simulation output, datapath unchanged
`endif

endmodule
